// File: rtl/exibe_sequencia.sv
// Plays back a stored sequence of LED codes, lighting each for T_ACESO cycles with a T_APAGADO dark gap.
// Optional macro EXIBE_SEQUENCIA_CANCELA_EN adds a 'cancela' input that aborts a run back to idle.
module exibe_sequencia #(
  parameter int T_ACESO   = 500,
  parameter int T_APAGADO = 250,
  parameter int TMR_W     = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
`ifdef EXIBE_SEQUENCIA_CANCELA_EN
  input  logic       cancela,
`endif
  input  logic [3:0] limite,
  input  logic [3:0] mem_dado,
  output logic [3:0] mem_endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       fim,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    s_ocioso  = 3'd0,
    s_carrega = 3'd1,
    s_aceso   = 3'd2,
    s_apagado = 3'd3,
    s_proximo = 3'd4,
    s_final   = 3'd5
  } estado_t;

  localparam logic [TMR_W-1:0] ACESO_FIM   = TMR_W'(T_ACESO - 1);
  localparam logic [TMR_W-1:0] APAGADO_FIM = TMR_W'(T_APAGADO - 1);

  estado_t          estado, prox_estado;
  logic [TMR_W-1:0] timer, timer_prox;
  logic [3:0]       limite_r, limite_prox;
  logic [3:0]       dado_r, dado_prox;
  logic [3:0]       endereco_prox;
  logic             cancelar;

`ifdef EXIBE_SEQUENCIA_CANCELA_EN
  assign cancelar = cancela && (estado != s_ocioso);
`else
  assign cancelar = 1'b0;
`endif

  // leds is driven from the next state so it is valid in the very first aceso cycle
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado       <= s_ocioso;
      timer        <= '0;
      mem_endereco <= 4'h0;
      limite_r     <= 4'h0;
      dado_r       <= 4'h0;
      leds         <= 4'h0;
    end else begin
      estado       <= prox_estado;
      timer        <= timer_prox;
      mem_endereco <= endereco_prox;
      limite_r     <= limite_prox;
      dado_r       <= dado_prox;
      leds         <= (prox_estado == s_aceso) ? dado_prox : 4'h0;
    end
  end

  always_comb begin
    prox_estado   = estado;
    timer_prox    = timer;
    endereco_prox = mem_endereco;
    limite_prox   = limite_r;
    dado_prox     = dado_r;
    case (estado)
      s_ocioso: begin
        if (iniciar) begin
          limite_prox   = limite;
          endereco_prox = 4'h0;
          timer_prox    = '0;
          prox_estado   = s_carrega;
        end
      end
      s_carrega: begin
        dado_prox   = mem_dado;
        timer_prox  = '0;
        prox_estado = s_aceso;
      end
      s_aceso: begin
        if (timer == ACESO_FIM) begin
          timer_prox  = '0;
          prox_estado = s_apagado;
        end else begin
          timer_prox = timer + 1'b1;
        end
      end
      s_apagado: begin
        if (timer == APAGADO_FIM) begin
          timer_prox  = '0;
          prox_estado = (mem_endereco == limite_r) ? s_final : s_proximo;
        end else begin
          timer_prox = timer + 1'b1;
        end
      end
      s_proximo: begin
        endereco_prox = mem_endereco + 4'd1;
        prox_estado   = s_carrega;
      end
      s_final: begin
        prox_estado = s_ocioso;
      end
      default: begin
        prox_estado = s_ocioso;
      end
    endcase
    if (cancelar) begin
      prox_estado   = s_ocioso;
      endereco_prox = 4'h0;
      timer_prox    = '0;
    end
  end

  assign ocupado = (estado != s_ocioso);
  assign fim     = (estado == s_final);

  always_comb begin
    case (estado)
      s_ocioso, s_carrega, s_aceso, s_apagado, s_proximo, s_final:
        db_estado = {1'b0, estado};
      default:
        db_estado = 4'hF;
    endcase
  end

endmodule

// File: doc/exibe_sequencia.md
EXIBE_SEQUENCIA -- requirements
Module: exibe_sequencia

Interface
REQ-001 The block SHALL have parameter T_ACESO, default 500, giving the clock cycles each sequence element is lit.
REQ-002 The block SHALL have parameter T_APAGADO, default 250, giving the dark gap in clock cycles after each element.
REQ-003 The block SHALL have parameter TMR_W, default 16, giving the timer width; T_ACESO and T_APAGADO SHALL be between 1 and 2^TMR_W-1.
REQ-004 Port: clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 Port: reset_n  in  1  synchronous, active-low reset.
REQ-006 Port: iniciar  in  1  start request; sampled only in ocioso.
REQ-007 Port: limite  in  4  address of the last element to show (sequence length minus 1).
REQ-008 Port: mem_dado  in  4  one-hot play code read combinationally from the sequence memory at mem_endereco.
REQ-009 Port: mem_endereco  out  4  memory read address, registered.
REQ-010 Port: leds  out  4  player-visible LEDs, registered.
REQ-011 Port: ocupado  out  1  high in every state except ocioso.
REQ-012 Port: fim  out  1  single-cycle done pulse.
REQ-013 Port: db_estado  out  4  state code, for debug.

Function
REQ-014 The FSM SHALL use these states and codes: ocioso=0, carrega=1, aceso=2, apagado=3, proximo=4, final=5; any other code SHALL go to ocioso and drive db_estado=F.
REQ-015 In ocioso with iniciar=1, the block SHALL latch limite into limite_r, clear mem_endereco and the timer, and go to carrega; with iniciar=0 it SHALL stay in ocioso.
REQ-016 In carrega, the block SHALL latch mem_dado into dado_r, clear the timer, and go to aceso; it SHALL stay in carrega for exactly 1 cycle.
REQ-017 In aceso, leds SHALL equal dado_r and the timer SHALL increment; when timer==T_ACESO-1 the block SHALL clear the timer and go to apagado, so it stays in aceso for exactly T_ACESO cycles.
REQ-018 In apagado, leds SHALL be 0 and the timer SHALL increment; when timer==T_APAGADO-1 the block SHALL go to final if mem_endereco==limite_r, otherwise to proximo.
REQ-019 In proximo, mem_endereco SHALL increment by 1 and the block SHALL go to carrega; it stays there for 1 cycle.
REQ-020 In final, fim SHALL be 1 for exactly 1 cycle, then the block SHALL go to ocioso.
REQ-021 leds SHALL be 0 in every state except aceso.
REQ-022 iniciar and changes on limite while ocupado=1 SHALL be ignored, because only limite_r is used.
REQ-023 limite=F SHALL show all 16 addresses; mem_endereco SHALL never wrap during a run.
REQ-024 A run SHALL last (limite+1)*(1+T_ACESO+T_APAGADO)+limite+1 ocupado cycles, final included.
REQ-025 mem_dado SHALL be passed through unchecked; a non-one-hot value SHALL be shown as-is.

Reset
REQ-026 With reset_n=0 at a rising edge, the block SHALL go to ocioso; mem_endereco, leds, the timer, limite_r and dado_r SHALL be 0, ocupado=0, fim=0, db_estado=0.
REQ-027 Reset asserted mid-run SHALL abort the run with no fim pulse, and leds SHALL be 0 on the next cycle.
REQ-028 Reset SHALL take priority over iniciar and over every transition.

Configuration
REQ-029 With macro EXIBE_SEQUENCIA_CANCELA_EN defined, the block SHALL have an extra input cancela (1 bit); cancela=1 in any state other than ocioso SHALL force ocioso on the next edge with leds=0, mem_endereco=0 and no fim pulse, and cancela SHALL take priority over all transitions except reset.
REQ-030 Without EXIBE_SEQUENCIA_CANCELA_EN, the cancela port SHALL be absent and the behaviour SHALL be exactly REQ-014 to REQ-028.

Verification (T_ACESO=4, T_APAGADO=2)
REQ-031 Reset: reset_n=0 for 2 cycles -> db_estado=0, leds=0, ocupado=0, fim=0, mem_endereco=0.
REQ-032 Single element: limite=0, mem_dado=4'b0010, 1-cycle iniciar pulse -> leds=0010 for exactly 4 cycles, then 0 for 2 cycles, fim pulse 1 cycle, 8 ocupado cycles in total.
REQ-033 Three elements: memory {0001,0100,1000}, limite=2 -> leds show 0001, 0100, 1000 for 4 cycles each with 2-cycle gaps, mem_endereco steps 0,1,2, fim once, 24 ocupado cycles.
REQ-034 Busy robustness: iniciar held high and limite changed to F during a limite=1 run -> run ends after address 1, fim once; with iniciar still high, a new run starts the cycle after returning to ocioso.
REQ-035 Mid-run reset: reset_n=0 during aceso of address 1 -> the next cycle has db_estado=0 and leds=0, and fim is never asserted.
REQ-036 Cancel (macro defined): cancela=1 during apagado of address 0 with limite=3 -> ocioso on the next cycle, mem_endereco=0, no fim.
